fir_mac_engine: RTL and testbench
=================================

# fir_mac_engine

FIR multiply-accumulate datapath directly downstream of the FIR streamer. It consumes the 16-bit `x` (sample) and `h` (coefficient) HWPE-Streams that the streamer serializes from TCDM. For each output it reduces `nb_taps` x·h pairs into one saturated `y` sample. It returns the `y` stream to the streamer's `y` FIFO for deserialization and write-back, and reports completion to the FIR controller.

## Interface
Parameters:
- `DATA_WIDTH`, 16, signed width of x, h and y samples.
- `ACC_WIDTH`, 40, signed accumulator width; must be ≥ 2·DATA_WIDTH.
- `CNT_WIDTH`, 16, width of the tap and output counters.

Ports:
- `clk_i` input 1: clock; all state on rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `enable_i` input 1: local enable; low freezes all state and forces both input readys low.
- `clear_i` input 1: synchronous clear, same effect as reset.
- `start_i` input 1: one-cycle job start; sampled only in IDLE.
- `nb_taps_i` input CNT_WIDTH: x·h pairs per output; latched at start.
- `nb_outputs_i` input CNT_WIDTH: outputs per job; latched at start.
- `shift_i` input 6: right shift applied to the accumulator; latched at start.
- `x_i` hwpe_stream_intf_stream.sink, DATA_WIDTH: samples.
- `h_i` hwpe_stream_intf_stream.sink, DATA_WIDTH: coefficients.
- `y_o` hwpe_stream_intf_stream.source, DATA_WIDTH: results; strb all ones.
- `busy_o` output 1: high while not in IDLE.
- `done_o` output 1: one-cycle pulse at job end.

## Operation
- FSM states:
  - IDLE: `start_i` with both counts nonzero → RUN; with either count zero → DONE.
  - RUN: after the handshake of the last output → DONE.
  - DONE: asserts `done_o` for one cycle → IDLE.
- Input join: a pair is consumed only when both `x_i` and `h_i` are valid.
  - `x_i.ready = h_i.ready = RUN & enable_i & x_i.valid & h_i.valid & !p_stall & (issued_outputs < nb_outputs)`.
- Input-side counters: `in_tap` counts 0..nb_taps-1 and wraps. `issued_outputs` increments on each wrap. The pair at `in_tap == nb_taps-1` is tagged last.
- Stage P: registers the full-width signed product, 2·DATA_WIDTH bits, together with its valid and last tags.
- Stage A:
  - Non-last product: `acc <= acc + sext(prod)`.
  - Last product: computes `acc + sext(prod)`, shifts it arithmetically right by `shift`, saturates it to DATA_WIDTH signed range, loads it into the y register, and sets `acc <= 0`.
- Output:
  - `y_o.valid` is held until `y_o.ready`; data stays stable while valid.
  - `out_cnt` increments on each y handshake.
  - RUN exits when `out_cnt` reaches `nb_outputs`.
- Stalls:
  - `a_stall = prod_valid_q & prod_last_q & y_valid_q & !y_o.ready`.
  - `p_stall = a_stall`.
  - A non-last product never stalls.
- Boundaries:
  - `start_i` outside IDLE is ignored.
  - `nb_taps = 1`: every pair is last.
  - Saturation bounds: +32767 and -32768 for DATA_WIDTH = 16.
  - Accumulator overflow within ACC_WIDTH wraps, two's complement; it is not flagged.
  - Input beats arriving after all outputs have been issued are left unconsumed.
- `clear_i` or `rst_i` mid-job: FSM → IDLE, all counters, accumulator and valids → 0, no `done_o` pulse. The partial result is discarded.

## Timing
- Reset values: `x_i.ready`, `h_i.ready`, `y_o.valid`, `y_o.data`, `busy_o` and `done_o` are all 0; FSM is in IDLE.
- Latency: `y_o.valid` rises 2 cycles after the handshake of the last tap, i.e. edge +1 P, edge +2 A/y.
- Throughput: one pair per cycle with no bubbles when inputs are valid and `y_o` is ready; one output every `nb_taps` cycles.
- `busy_o` rises the cycle after `start_i`.
- `done_o` rises the cycle after the final y handshake, or the cycle after `start_i` for a zero-count job.
- `enable_i` low: no state change and readys low; `y_o.valid` and data hold.

## Configuration
- `FIR_MAC_ROUND_EN` defined: before the shift, adds `1 << (shift-1)` when `shift > 0`, giving round-half-up; saturation follows.
- `FIR_MAC_ROUND_EN` undefined: plain arithmetic-shift truncation, no rounding adder.

## Test plan
- taps=4, outputs=1, shift=0, x={1,2,3,4}, h={1,1,1,1}, y always ready → y=10 two cycles after the 4th pair; `done_o` one cycle after the y handshake.
- taps=2, outputs=3, x=h=0x7FFF continuous → y=32767 ×3 (saturated); readys stay high for 6 consecutive cycles.
- taps=1, outputs=4, `y_o.ready` held low 5 cycles → y register holds the first result; inputs stall after 2 pairs; all 4 outputs are correct once ready rises.
- shift=1, x={3}, h={1}, taps=1 → y=1 without the macro, y=2 with `FIR_MAC_ROUND_EN`.
- `clear_i` mid-job after 3 of 8 pairs, then a new start with taps=2 → no `done_o` pulse; the next y equals the fresh sum with no residue.
- `start_i` with `nb_outputs=0` → `done_o` pulse the next cycle; no input consumed.

Source files
------------

// File: rtl/fir_mac_engine.sv
// FIR multiply-accumulate engine: joins x/h streams, accumulates nb_taps products, emits saturated y.
// Optional FIR_MAC_ROUND_EN adds round-half-up before the output shift.
module fir_mac_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [CNT_WIDTH-1:0]    nb_taps_i,
    input  logic [CNT_WIDTH-1:0]    nb_outputs_i,
    input  logic [5:0]              shift_i,
    input  logic                    x_valid_i,
    output logic                    x_ready_o,
    input  logic [DATA_WIDTH-1:0]   x_data_i,
    input  logic                    h_valid_i,
    output logic                    h_ready_o,
    input  logic [DATA_WIDTH-1:0]   h_data_i,
    output logic                    y_valid_o,
    input  logic                    y_ready_i,
    output logic [DATA_WIDTH-1:0]   y_data_o,
    output logic [DATA_WIDTH/8-1:0] y_strb_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int PW = 2 * DATA_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] YMAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] YMIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                       state_q, state_d;
    logic [CNT_WIDTH-1:0]         taps_q, taps_d;
    logic [CNT_WIDTH-1:0]         outs_q, outs_d;
    logic [5:0]                   shift_q, shift_d;
    logic [CNT_WIDTH-1:0]         in_tap_q, in_tap_d;
    logic [CNT_WIDTH-1:0]         issued_q, issued_d;
    logic [CNT_WIDTH-1:0]         out_cnt_q, out_cnt_d;
    logic signed [PW-1:0]         prod_q, prod_d;
    logic                         prod_valid_q, prod_valid_d;
    logic                         prod_last_q, prod_last_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [DATA_WIDTH-1:0]        y_q, y_d;
    logic                         y_valid_q, y_valid_d;

    logic                         a_stall;
    logic                         p_stall;
    logic                         in_fire;
    logic                         in_last;
    logic                         y_hs;
    logic signed [PW-1:0]         prod_mul;
    logic signed [ACC_WIDTH-1:0]  acc_sum;
    logic signed [ACC_WIDTH-1:0]  acc_rnd;
    logic signed [ACC_WIDTH-1:0]  acc_shr;
    logic [DATA_WIDTH-1:0]        y_sat;

    // Only a last product needs the y register, so only it can back-pressure.
    assign a_stall = prod_valid_q & prod_last_q & y_valid_q & ~y_ready_i;
    assign p_stall = a_stall;

    assign in_fire = (state_q == RUN) & enable_i & x_valid_i & h_valid_i
                   & ~p_stall & (issued_q < outs_q);
    assign in_last = (in_tap_q == taps_q - CNT_WIDTH'(1));
    assign y_hs    = y_valid_q & y_ready_i & enable_i;

    assign prod_mul = PW'($signed(x_data_i)) * PW'($signed(h_data_i));
    assign acc_sum  = acc_q + ACC_WIDTH'(prod_q);

`ifdef FIR_MAC_ROUND_EN
    logic signed [ACC_WIDTH-1:0] rnd;
    always_comb begin
        rnd = '0;
        if (shift_q != 6'd0) begin
            rnd = ACC_WIDTH'(1) << (shift_q - 6'd1);
        end
    end
    assign acc_rnd = acc_sum + rnd;
`else
    assign acc_rnd = acc_sum;
`endif

    assign acc_shr = acc_rnd >>> shift_q;

    always_comb begin
        y_sat = acc_shr[DATA_WIDTH-1:0];
        if (acc_shr > YMAX) begin
            y_sat = YMAX[DATA_WIDTH-1:0];
        end else if (acc_shr < YMIN) begin
            y_sat = YMIN[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        taps_d       = taps_q;
        outs_d       = outs_q;
        shift_d      = shift_q;
        in_tap_d     = in_tap_q;
        issued_d     = issued_q;
        out_cnt_d    = out_cnt_q;
        prod_d       = prod_q;
        prod_valid_d = prod_valid_q;
        prod_last_d  = prod_last_q;
        acc_d        = acc_q;
        y_d          = y_q;
        y_valid_d    = y_valid_q;

        if (enable_i) begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        taps_d    = nb_taps_i;
                        outs_d    = nb_outputs_i;
                        shift_d   = shift_i;
                        in_tap_d  = '0;
                        issued_d  = '0;
                        out_cnt_d = '0;
                        if (nb_taps_i == '0 || nb_outputs_i == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (y_hs && (out_cnt_q + CNT_WIDTH'(1) == outs_q)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (in_fire) begin
                if (in_last) begin
                    in_tap_d = '0;
                    issued_d = issued_q + CNT_WIDTH'(1);
                end else begin
                    in_tap_d = in_tap_q + CNT_WIDTH'(1);
                end
            end

            if (!p_stall) begin
                prod_valid_d = in_fire;
                prod_last_d  = in_fire & in_last;
                prod_d       = prod_mul;
            end

            if (y_hs) begin
                y_valid_d = 1'b0;
                out_cnt_d = out_cnt_q + CNT_WIDTH'(1);
            end

            // A last product may load y in the same cycle the old y leaves.
            if (prod_valid_q && !a_stall) begin
                if (prod_last_q) begin
                    y_d       = y_sat;
                    y_valid_d = 1'b1;
                    acc_d     = '0;
                end else begin
                    acc_d = acc_sum;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            taps_q       <= '0;
            outs_q       <= '0;
            shift_q      <= '0;
            in_tap_q     <= '0;
            issued_q     <= '0;
            out_cnt_q    <= '0;
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            prod_last_q  <= 1'b0;
            acc_q        <= '0;
            y_q          <= '0;
            y_valid_q    <= 1'b0;
        end else if (clear_i) begin
            state_q      <= IDLE;
            taps_q       <= '0;
            outs_q       <= '0;
            shift_q      <= '0;
            in_tap_q     <= '0;
            issued_q     <= '0;
            out_cnt_q    <= '0;
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            prod_last_q  <= 1'b0;
            acc_q        <= '0;
            y_q          <= '0;
            y_valid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            taps_q       <= taps_d;
            outs_q       <= outs_d;
            shift_q      <= shift_d;
            in_tap_q     <= in_tap_d;
            issued_q     <= issued_d;
            out_cnt_q    <= out_cnt_d;
            prod_q       <= prod_d;
            prod_valid_q <= prod_valid_d;
            prod_last_q  <= prod_last_d;
            acc_q        <= acc_d;
            y_q          <= y_d;
            y_valid_q    <= y_valid_d;
        end
    end

    assign x_ready_o = in_fire;
    assign h_ready_o = in_fire;
    assign y_valid_o = y_valid_q;
    assign y_data_o  = y_q;
    assign y_strb_o  = '1;
    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == DONE);

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed-vector bench for fir_mac_engine.
// Expected y values follow FIR_MAC_ROUND_EN when the macro is defined.
module tb_fir_mac_engine;

    localparam int DW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          clr;
    logic          start;
    logic [CW-1:0] taps;
    logic [CW-1:0] outs;
    logic [5:0]    sh;
    logic          xv, xr, hv, hr, yv, yr;
    logic [DW-1:0] xd, hd, yd;
    logic [1:0]    ys;
    logic          busy, done;

    fir_mac_engine #(.DATA_WIDTH(DW), .ACC_WIDTH(40), .CNT_WIDTH(CW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (en),
        .clear_i      (clr),
        .start_i      (start),
        .nb_taps_i    (taps),
        .nb_outputs_i (outs),
        .shift_i      (sh),
        .x_valid_i    (xv),
        .x_ready_o    (xr),
        .x_data_i     (xd),
        .h_valid_i    (hv),
        .h_ready_o    (hr),
        .h_data_i     (hd),
        .y_valid_o    (yv),
        .y_ready_i    (yr),
        .y_data_o     (yd),
        .y_strb_o     (ys),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] xq[$];
    logic [DW-1:0] hq[$];
    logic [DW-1:0] yq[$];

    int n_pairs, n_done, first_pc, last_pc, yrise_c, yhs_c, done_c, start_c;
    bit in_hs   = 1'b0;
    bit prev_yv = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] yat(input int i);
        if (i < yq.size()) return yq[i];
        return 16'hdead;
    endfunction

    always @(negedge clk) begin
        in_hs = xv & xr & hv & hr;
        if (in_hs) begin
            if (n_pairs == 0) first_pc = cyc;
            last_pc = cyc;
            n_pairs++;
        end
        if (yv & yr & en) begin
            yq.push_back(yd);
            yhs_c = cyc;
        end
        if (yv & !prev_yv) yrise_c = cyc;
        prev_yv = yv;
        if (done) begin
            n_done++;
            done_c = cyc;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (in_hs && xq.size() > 0) begin
                void'(xq.pop_front());
                void'(hq.pop_front());
            end
            xv = (xq.size() > 0);
            hv = (hq.size() > 0);
            xd = xv ? xq[0] : '0;
            hd = hv ? hq[0] : '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clr_mon();
        n_pairs  = 0;
        n_done   = 0;
        first_pc = -1;
        last_pc  = -1;
        yrise_c  = -1;
        yhs_c    = -1;
        done_c   = -1;
        yq.delete();
    endtask

    task automatic push(input logic [DW-1:0] x, input logic [DW-1:0] h);
        xq.push_back(x);
        hq.push_back(h);
    endtask

    task automatic do_start(input int t, input int o, input int s);
        taps    = CW'(t);
        outs    = CW'(o);
        sh      = 6'(s);
        start   = 1'b1;
        start_c = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        int k = 0;
        while (n_done == 0 && k < lim) begin
            tick();
            k++;
        end
        check(tag, n_done, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b1; clr = 1'b0; start = 1'b0;
        taps = '0; outs = '0; sh = '0; yr = 1'b1;
        xv = 1'b0; hv = 1'b0; xd = '0; hd = '0;
        clr_mon();
        repeat (3) tick();
        check("rst_xready", xr, 0);
        check("rst_hready", hr, 0);
        check("rst_yvalid", yv, 0);
        check("rst_ydata", yd, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("strb", ys, 2'b11);
        rst = 1'b0;
        tick();

        // basic 4-tap sum, latency and done timing
        clr_mon();
        for (int i = 1; i <= 4; i++) push(16'(i), 16'd1);
        do_start(4, 1, 0);
        check("t1_busy_rise", busy, 1);
        wait_done("t1_done", 40);
        check("t1_ny", yq.size(), 1);
        check("t1_y", yat(0), 16'd10);
        check("t1_latency", yrise_c - last_pc, 2);
        check("t1_done_cyc", done_c - yhs_c, 1);
        repeat (3) tick();
        check("t1_one_pulse", n_done, 1);
        check("t1_busy_fall", busy, 0);

        // positive saturation, back-to-back pairs
        clr_mon();
        for (int i = 0; i < 6; i++) push(16'h7fff, 16'h7fff);
        do_start(2, 3, 0);
        wait_done("t2_done", 60);
        check("t2_ny", yq.size(), 3);
        for (int i = 0; i < 3; i++) check("t2_y", yat(i), 16'h7fff);
        check("t2_pairs", n_pairs, 6);
        check("t2_contig", last_pc - first_pc, 5);

        // y back-pressure with taps=1
        clr_mon();
        yr = 1'b0;
        push(16'd1, 16'd5); push(16'd2, 16'd6);
        push(16'd3, 16'd7); push(16'd4, 16'd8);
        do_start(1, 4, 0);
        repeat (6) tick();
        check("t3_stall_pairs", n_pairs, 2);
        check("t3_hold_valid", yv, 1);
        check("t3_hold_data", yd, 16'd5);
        yr = 1'b1;
        wait_done("t3_done", 60);
        check("t3_ny", yq.size(), 4);
        check("t3_y0", yat(0), 16'd5);
        check("t3_y1", yat(1), 16'd12);
        check("t3_y2", yat(2), 16'd21);
        check("t3_y3", yat(3), 16'd32);

        // shift by one, positive and negative
        clr_mon();
        push(16'd3, 16'd1);
        push(16'hfffd, 16'd1);
        do_start(1, 2, 1);
        wait_done("t4_done", 40);
`ifdef FIR_MAC_ROUND_EN
        check("t4_y0", yat(0), 16'd2);
        check("t4_y1", yat(1), 16'hffff);
`else
        check("t4_y0", yat(0), 16'd1);
        check("t4_y1", yat(1), 16'hfffe);
`endif
        tick();

        // negative saturation
        clr_mon();
        push(16'h8000, 16'h7fff);
        push(16'h8000, 16'h7fff);
        do_start(2, 1, 0);
        wait_done("t5a_done", 40);
        check("t5a_y", yat(0), 16'h8000);
        tick();

        // in-range shift: 100000 >> 4
        clr_mon();
        push(16'd1000, 16'd100);
        do_start(1, 1, 4);
        wait_done("t5b_done", 40);
        check("t5b_y", yat(0), 16'd6250);
        tick();

        // mixed signs: 300 - 200 - 14
        clr_mon();
        push(16'd100, 16'd3);
        push(16'hffce, 16'd4);
        push(16'd7, 16'hfffe);
        do_start(3, 1, 0);
        wait_done("t5c_done", 40);
        check("t5c_y", yat(0), 16'd86);
        tick();

        // clear mid-job discards the partial sum
        clr_mon();
        for (int i = 0; i < 3; i++) push(16'd5, 16'd1);
        do_start(8, 1, 0);
        for (int k = 0; k < 20 && n_pairs < 3; k++) tick();
        check("t6_pairs", n_pairs, 3);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        check("t6_busy", busy, 0);
        check("t6_yvalid", yv, 0);
        check("t6_no_done", n_done, 0);
        clr_mon();
        push(16'd7, 16'd1);
        push(16'd9, 16'd2);
        do_start(2, 1, 0);
        wait_done("t6_done", 40);
        check("t6_y", yat(0), 16'd25);
        tick();

        // zero-count jobs
        clr_mon();
        push(16'd1, 16'd1);
        do_start(4, 0, 0);
        tick();
        check("t7_done_cyc", done_c - start_c, 1);
        repeat (3) tick();
        check("t7_no_pairs", n_pairs, 0);
        check("t7_one_pulse", n_done, 1);
        check("t7_busy", busy, 0);
        do_start(0, 2, 0);
        tick();
        check("t7b_done_cyc", done_c - start_c, 1);
        check("t7b_no_pairs", n_pairs, 0);
        xq.delete();
        hq.delete();
        repeat (2) tick();

        // enable low freezes the job
        clr_mon();
        push(16'd2, 16'd4);
        push(16'd3, 16'd5);
        do_start(2, 1, 0);
        tick();
        en = 1'b0;
        repeat (4) tick();
        check("t8_ready_low", xr, 0);
        check("t8_pairs", n_pairs, 1);
        check("t8_busy", busy, 1);
        check("t8_no_y", yv, 0);
        en = 1'b1;
        wait_done("t8_done", 40);
        check("t8_y", yat(0), 16'd23);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
